onehot_scan_encoder: RTL and testbench

Sequential 8-to-3 encoder: the inverse of the team's 3-to-8 decoder path. It accepts an N-bit request/minterm vector over a valid/ready handshake and emits the binary index of every set bit, one index per beat. Each set bit produces one beat, lowest index first by default, with a last flag on the final beat. It sits downstream of decoder-based logic, such as minterm-select datapaths, and converts multi-hot vectors back into an index stream for counters and muxes.

---
 rtl/onehot_scan_encoder_pkg.sv | 21 ++
 rtl/onehot_scan_encoder_if.sv | 27 ++
 rtl/onehot_scan_encoder_prio_enc.sv | 25 ++
 rtl/onehot_scan_encoder.sv | 75 +++++++
 tb/tb_onehot_scan_encoder.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/onehot_scan_encoder_pkg.sv
// Shared types and helpers for onehot_scan_encoder: FSM state, default width, one-hot test.
package enc_pkg;

  localparam int N_DEFAULT = 8;
  localparam int MAX_N     = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic logic is_onehot(input logic [MAX_N-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_N; i++) begin
      cnt = cnt + int'(v[i]);
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/onehot_scan_encoder_if.sv
// Vector-in / index-out handshake bundle; slave is the encoder side, master the producer/consumer side.
interface onehot_scan_encoder_if
  import enc_pkg::*;
#(
  parameter int N = N_DEFAULT
);
  localparam int W = $clog2(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic         out_none;

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_none
  );

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_none
  );
endinterface

// File: rtl/onehot_scan_encoder_prio_enc.sv
// Combinational N->W priority encoder, zero input gives 0; SCAN_HIGH_FIRST_EN picks the highest set bit.
module prio_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx
);

  always_comb begin
    o_idx = '0;
`ifdef SCAN_HIGH_FIRST_EN
    // Ascending sweep: the last hit, i.e. the highest set bit, wins.
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) o_idx = W'(i);
    end
`else
    // Descending sweep: the last hit, i.e. the lowest set bit, wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = W'(i);
    end
`endif
  end

endmodule

// File: rtl/onehot_scan_encoder.sv
// Multi-hot vector to index stream, one beat per set bit (one beat for zero); order set by SCAN_HIGH_FIRST_EN.
// First beat one cycle after accept; beats hold under out_ready low; in_ready reasserts on the accepted last beat.
module onehot_scan_encoder
  import enc_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  onehot_scan_encoder_if.slave  bus
);
  localparam int W = $clog2(N);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_pending;
  logic [N-1:0] w_pending_nxt;
  logic         r_zero;
  logic         w_zero_nxt;

  logic [W-1:0] w_idx;
  logic [N-1:0] w_idx_mask;
  logic         w_valid;
  logic         w_last;
  logic         w_fire;
  logic         w_in_rdy;
  logic         w_accept;

  prio_enc #(.N(N), .W(W)) u_prio_enc (
    .i_vec (r_pending),
    .o_idx (w_idx)
  );

  assign w_valid    = (r_state == SCAN);
  assign w_last     = w_valid & (r_zero | is_onehot(MAX_N'(r_pending)));
  assign w_fire     = w_valid & bus.out_ready;
  assign w_in_rdy   = (r_state == IDLE) | (w_fire & w_last);
  assign w_accept   = bus.in_valid & w_in_rdy;
  assign w_idx_mask = N'(1) << w_idx;

  assign bus.in_ready  = w_in_rdy;
  assign bus.out_valid = w_valid;
  assign bus.out_idx   = w_idx;
  assign bus.out_last  = w_last;
  assign bus.out_none  = w_valid & r_zero;

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_zero_nxt    = r_zero;
    if (w_fire) begin
      w_pending_nxt = r_pending & ~w_idx_mask;
      if (w_last) w_state_nxt = IDLE;
    end
    // A new vector overrides the retire above, giving a bubble-free hand-over.
    if (w_accept) begin
      w_pending_nxt = bus.in_vec;
      w_zero_nxt    = (bus.in_vec == '0);
      w_state_nxt   = SCAN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_zero    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_zero    <= w_zero_nxt;
    end
  end

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Scoreboard bench for onehot_scan_encoder: expected beats queued on accept, popped on each output beat.
module tb_onehot_scan_encoder;
  import enc_pkg::*;

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
    logic       none;
  } beat_t;

  logic   clk;
  logic   rst_n;
  int     checks;
  int     errors;
  logic   rand_rdy;
  beat_t  sb[$];

  onehot_scan_encoder_if #(.N(8)) bus ();

  onehot_scan_encoder #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_vec(input logic [7:0] v);
    beat_t b;
    int    k;
    int    n;
    int    pos;
    k = $countones(v);
    n = 0;
    if (k == 0) begin
      b.idx = 3'd0; b.last = 1'b1; b.none = 1'b1;
      sb.push_back(b);
    end else begin
      for (int j = 0; j < 8; j++) begin
`ifdef SCAN_HIGH_FIRST_EN
        pos = 7 - j;
`else
        pos = j;
`endif
        if (v[pos]) begin
          n++;
          b.idx = 3'(pos); b.last = (n == k); b.none = 1'b0;
          sb.push_back(b);
        end
      end
    end
  endtask

  // Monitor: what is visible at negedge is what the next rising edge commits.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("extra_beat", 32'(bus.out_valid), 32'd0);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("beat_idx",  32'(bus.out_idx),  32'(e.idx));
          check("beat_last", 32'(bus.out_last), 32'(e.last));
          check("beat_none", 32'(bus.out_none), 32'(e.none));
        end
      end
      if (bus.in_valid && bus.in_ready) push_vec(bus.in_vec);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] v);
    logic acc;
    int   t;
    acc = 1'b0;
    t   = 0;
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
      t++;
    end
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || bus.out_valid) && t < 300) begin
      step();
      t++;
    end
    check("drain_timeout", 32'(t < 300), 32'd1);
  endtask

  initial begin
    logic [2:0] first_bp;
    checks       = 0;
    errors       = 0;
    rand_rdy     = 1'b0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_vec   = '0;
    bus.out_ready = 1'b0;
`ifdef SCAN_HIGH_FIRST_EN
    first_bp = 3'd4;
`else
    first_bp = 3'd3;
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_idx",   32'(bus.out_idx),   32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    check("rst_out_none",  32'(bus.out_none),  32'd0);
    rst_n = 1'b1;
    step();

    // Multi-hot with sink always ready: four consecutive beats then idle.
    bus.out_ready = 1'b1;
    send(8'b1010_0110);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mh_valid", 32'(bus.out_valid), 32'd1);
    end
    @(negedge clk);
    check("mh_idle", 32'(bus.out_valid), 32'd0);
    check("mh_drained", 32'(sb.size()), 32'd0);
    step();

    // Zero vector: a single none beat.
    send(8'h00);
    @(negedge clk);
    check("zero_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    check("zero_idle", 32'(bus.out_valid), 32'd0);
    step();

    // Backpressure: first index held for three stalled cycles.
    bus.out_ready = 1'b0;
    send(8'b0001_1000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_idx", 32'(bus.out_idx), 32'(first_bp));
      check("bp_hold_last", 32'(bus.out_last), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_beat_valid", 32'(bus.out_valid), 32'd1);
      step();
    end
    wait_idle();

    // Back-to-back: the second vector is taken on the last beat of the first.
    bus.in_valid = 1'b1;
    bus.in_vec   = 8'h01;
    @(negedge clk);
    check("b2b_rdy_idle", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_vec = 8'h80;
    @(negedge clk);
    check("b2b_last", 32'(bus.out_last), 32'd1);
    check("b2b_rdy_last", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_no_gap", 32'(bus.out_valid), 32'd1);
    check("b2b_idx7", 32'(bus.out_idx), 32'd7);
    step();
    wait_idle();

    // Full vector: eight consecutive beats.
    send(8'hFF);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("full_valid", 32'(bus.out_valid), 32'd1);
    end
    @(negedge clk);
    check("full_idle", 32'(bus.out_valid), 32'd0);
    step();

    // Random vectors under random sink stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 25; i++) begin
      send(8'($urandom_range(0, 255)));
    end
    wait_idle();
    rand_rdy = 1'b0;
    bus.out_ready = 1'b0;
    step();

    // Reset mid-scan: one beat taken, remainder discarded.
    send(8'b1010_0110);
    bus.out_ready = 1'b1;
    @(negedge clk);
    step();
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_in_ready",  32'(bus.in_ready),  32'd1);
    check("mrst_out_last",  32'(bus.out_last),  32'd0);
    check("mrst_out_none",  32'(bus.out_none),  32'd0);
    sb.delete();
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mrst_quiet", 32'(bus.out_valid), 32'd0);
    end
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
